pong_ctrl: RTL and testbench

PONG_CTRL -- requirements
Module: pong_ctrl

---
 rtl/pong_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pong_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ctrl.sv
// Pong game controller: edge-detects hit/miss flags, keeps BCD scores and the rally count,
// and sequences IDLE/PLAY/SERVE/OVER. Define PONG_AUTO_SERVE_EN to leave SERVE on timer expiry alone.
module pong_ctrl #(
  parameter logic [7:0] WIN_SCORE  = 8'h11,
  parameter int         HOLD_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic [3:0] btn,
  input  logic       l_hit,
  input  logic       r_hit,
  input  logic       l_mis,
  input  logic       r_mis,
  output logic       gra_still,
  output logic [7:0] l_score,
  output logic [7:0] r_score,
  output logic [7:0] rally,
  output logic       game_over,
  output logic       winner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] res;
    if (v == 8'h99) begin
      res = v;
    end else if (v[3:0] == 4'h9) begin
      res = {v[7:4] + 4'h1, 4'h0};
    end else begin
      res = {v[7:4], v[3:0] + 4'h1};
    end
    return res;
  endfunction

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       l_hit_r;
  logic       r_hit_r;
  logic       l_mis_r;
  logic       r_mis_r;
  logic [7:0] timer_r;
  logic [7:0] timer_nxt_s;
  logic [7:0] l_score_r;
  logic [7:0] l_score_nxt_s;
  logic [7:0] r_score_r;
  logic [7:0] r_score_nxt_s;
  logic [7:0] rally_r;
  logic [7:0] rally_nxt_s;
  logic       winner_r;
  logic       winner_nxt_s;
  logic       gra_still_r;
  logic       game_over_r;
  logic [7:0] l_inc_s;
  logic [7:0] r_inc_s;
  logic       l_mis_ev_s;
  logic       r_mis_ev_s;
  logic       hit_ev_s;
  logic       btn_press_s;

  assign l_mis_ev_s  = l_mis & ~l_mis_r;
  assign r_mis_ev_s  = r_mis & ~r_mis_r;
  assign hit_ev_s    = (l_hit & ~l_hit_r) | (r_hit & ~r_hit_r);
  assign btn_press_s = |btn;
  assign l_inc_s     = bcd_inc(l_score_r);
  assign r_inc_s     = bcd_inc(r_score_r);

  // Next-state, score, rally and hold-timer logic.
  always_comb begin
    state_nxt_s   = state_r;
    l_score_nxt_s = l_score_r;
    r_score_nxt_s = r_score_r;
    rally_nxt_s   = rally_r;
    winner_nxt_s  = winner_r;
    if (refresh_tick && (timer_r != 8'h00)) begin
      timer_nxt_s = timer_r - 8'h01;
    end else begin
      timer_nxt_s = timer_r;
    end

    case (state_r)
      IDLE: begin
        if (btn_press_s) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PLAY: begin
        // A left miss wins a tie: only the right player scores.
        if (l_mis_ev_s) begin
          r_score_nxt_s = r_inc_s;
          rally_nxt_s   = 8'h00;
          timer_nxt_s   = HOLD_LOAD;
          if (r_inc_s == WIN_SCORE) begin
            state_nxt_s  = OVER;
            winner_nxt_s = 1'b1;
          end else begin
            state_nxt_s = SERVE;
          end
        end else if (r_mis_ev_s) begin
          l_score_nxt_s = l_inc_s;
          rally_nxt_s   = 8'h00;
          timer_nxt_s   = HOLD_LOAD;
          if (l_inc_s == WIN_SCORE) begin
            state_nxt_s  = OVER;
            winner_nxt_s = 1'b0;
          end else begin
            state_nxt_s = SERVE;
          end
        end else if (hit_ev_s && (rally_r != 8'hFF)) begin
          rally_nxt_s = rally_r + 8'h01;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
        if (timer_r == 8'h00) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = SERVE;
        end
`else
        if ((timer_r == 8'h00) && btn_press_s) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = SERVE;
        end
`endif
      end
      OVER: begin
        if (timer_r == 8'h00) begin
          state_nxt_s   = IDLE;
          l_score_nxt_s = 8'h00;
          r_score_nxt_s = 8'h00;
          rally_nxt_s   = 8'h00;
          winner_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = OVER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, edge-detect copies and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      l_hit_r     <= 1'b0;
      r_hit_r     <= 1'b0;
      l_mis_r     <= 1'b0;
      r_mis_r     <= 1'b0;
      timer_r     <= 8'h00;
      l_score_r   <= 8'h00;
      r_score_r   <= 8'h00;
      rally_r     <= 8'h00;
      winner_r    <= 1'b0;
      gra_still_r <= 1'b1;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      l_hit_r     <= l_hit;
      r_hit_r     <= r_hit;
      l_mis_r     <= l_mis;
      r_mis_r     <= r_mis;
      timer_r     <= timer_nxt_s;
      l_score_r   <= l_score_nxt_s;
      r_score_r   <= r_score_nxt_s;
      rally_r     <= rally_nxt_s;
      winner_r    <= winner_nxt_s;
      gra_still_r <= (state_nxt_s != PLAY);
      game_over_r <= (state_nxt_s == OVER);
    end
  end

  assign gra_still = gra_still_r;
  assign l_score   = l_score_r;
  assign r_score   = r_score_r;
  assign rally     = rally_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl: a WIN_SCORE=8'h11 instance and a never-winning instance
// (for BCD saturation) share one stimulus stream; HOLD_TICKS is shortened to 4.
module tb_pong_ctrl;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       refresh_tick;
  logic [3:0] btn;
  logic       l_hit, r_hit, l_mis, r_mis;

  logic       gra_still_a, game_over_a, winner_a;
  logic [7:0] l_score_a, r_score_a, rally_a;
  logic       gra_still_b, game_over_b, winner_b;
  logic [7:0] l_score_b, r_score_b, rally_b;

  int checks = 0;
  int errors = 0;

  pong_ctrl #(.WIN_SCORE(8'h11), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn),
    .l_hit(l_hit), .r_hit(r_hit), .l_mis(l_mis), .r_mis(r_mis),
    .gra_still(gra_still_a), .l_score(l_score_a), .r_score(r_score_a),
    .rally(rally_a), .game_over(game_over_a), .winner(winner_a)
  );

  pong_ctrl #(.WIN_SCORE(8'hFF), .HOLD_TICKS(HOLD)) dut_sat (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn),
    .l_hit(l_hit), .r_hit(r_hit), .l_mis(l_mis), .r_mis(r_mis),
    .gra_still(gra_still_b), .l_score(l_score_b), .r_score(r_score_b),
    .rally(rally_b), .game_over(game_over_b), .winner(winner_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic miss(input logic lm, input logic rm);
    l_mis = lm;
    r_mis = rm;
    tick();
    l_mis = 1'b0;
    r_mis = 1'b0;
    tick();
  endtask

  // Let the hold timer expire, then get back into PLAY.
  task automatic resume();
    refresh_tick = 1'b1;
    repeat (HOLD) tick();
    refresh_tick = 1'b0;
    tick();
`ifndef PONG_AUTO_SERVE_EN
    btn = 4'b0010;
    tick();
    btn = 4'b0000;
`endif
    tick();
  endtask

  initial begin
    reset = 1'b1; refresh_tick = 1'b0; btn = 4'b0000;
    l_hit = 1'b0; r_hit = 1'b0; l_mis = 1'b0; r_mis = 1'b0;

    // Asynchronous reset, observed before any clock edge
    #2 reset = 1'b0; btn = 4'b0001; l_mis = 1'b1;
    #1;
    check1("rst_gra_still", gra_still_a, 1'b1);
    check8("rst_l_score", l_score_a, 8'h00);
    check8("rst_r_score", r_score_a, 8'h00);
    check8("rst_rally", rally_a, 8'h00);
    check1("rst_game_over", game_over_a, 1'b0);
    check1("rst_winner", winner_a, 1'b0);
    tick(); tick();
    check1("rst_btn_ignored", gra_still_a, 1'b1);

    // Release with l_mis already high: no event
    btn = 4'b0000; reset = 1'b1;
    tick();
    check1("idle_after_release", gra_still_a, 1'b1);
    btn = 4'b0001;
    tick();
    btn = 4'b0000;
    check1("start_play", gra_still_a, 1'b0);
    tick();
    check8("no_evt_after_reset", r_score_a, 8'h00);
    check1("still_play", gra_still_a, 1'b0);
    l_mis = 1'b0;
    tick();

    // l_mis held for 50 clocks scores once
    l_mis = 1'b1;
    tick();
    check8("miss_first", r_score_a, 8'h01);
    check1("miss_still", gra_still_a, 1'b1);
    repeat (49) tick();
    check8("miss_level", r_score_a, 8'h01);
    l_mis = 1'b0;
    tick();

    refresh_tick = 1'b1;
    repeat (HOLD - 1) tick();
    check1("serve_before_expiry", gra_still_a, 1'b1);
    tick();
    refresh_tick = 1'b0;
`ifdef PONG_AUTO_SERVE_EN
    tick();
    check1("auto_serve", gra_still_a, 1'b0);
`else
    repeat (5) tick();
    check1("serve_waits_btn", gra_still_a, 1'b1);
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    check1("serve_btn", gra_still_a, 1'b0);
`endif

    // Rally counting
    repeat (3) begin l_hit = 1'b1; tick(); l_hit = 1'b0; tick(); end
    repeat (2) begin r_hit = 1'b1; tick(); r_hit = 1'b0; tick(); end
    check8("rally_5", rally_a, 8'h05);
    l_hit = 1'b1; r_hit = 1'b1; tick(); l_hit = 1'b0; r_hit = 1'b0; tick();
    check8("rally_both", rally_a, 8'h06);
    r_hit = 1'b1; repeat (10) tick(); r_hit = 1'b0; tick();
    check8("rally_level", rally_a, 8'h07);
    r_mis = 1'b1; tick(); r_mis = 1'b0;
    check8("r_mis_score", l_score_a, 8'h01);
    check8("rally_clear", rally_a, 8'h00);
    check8("r_score_kept", r_score_a, 8'h01);
    tick();
    l_hit = 1'b1; tick(); l_hit = 1'b0; tick();
    check8("hit_in_serve", rally_a, 8'h00);
    l_mis = 1'b1; tick(); l_mis = 1'b0; tick();
    check8("miss_in_serve", r_score_a, 8'h01);
    resume();

    // Simultaneous misses: left miss wins
    l_mis = 1'b1; r_mis = 1'b1; tick(); l_mis = 1'b0; r_mis = 1'b0;
    check8("tie_r_score", r_score_a, 8'h02);
    check8("tie_l_score", l_score_a, 8'h01);
    tick();
    resume();

    // BCD carry 09 -> 10
    repeat (8) begin miss(1'b0, 1'b1); resume(); end
    check8("l_score_09", l_score_a, 8'h09);
    miss(1'b0, 1'b1);
    check8("bcd_carry", l_score_a, 8'h10);
    resume();

    // Right player reaches WIN_SCORE
    repeat (8) begin miss(1'b1, 1'b0); resume(); end
    check8("r_score_10", r_score_a, 8'h10);
    miss(1'b1, 1'b0);
    check8("win_r_score", r_score_a, 8'h11);
    check1("game_over", game_over_a, 1'b1);
    check1("winner_right", winner_a, 1'b1);
    check1("over_still", gra_still_a, 1'b1);
    check1("sat_no_over", game_over_b, 1'b0);

    refresh_tick = 1'b1;
    repeat (HOLD - 1) tick();
    check1("over_hold", game_over_a, 1'b1);
    check8("over_scores_held", r_score_a, 8'h11);
    tick();
    refresh_tick = 1'b0;
    btn = 4'b1000;
    tick();
    check1("over_to_idle", game_over_a, 1'b0);
    check8("idle_l_score", l_score_a, 8'h00);
    check8("idle_r_score", r_score_a, 8'h00);
    check1("idle_winner", winner_a, 1'b0);
    check1("idle_still", gra_still_a, 1'b1);
    tick();
    btn = 4'b0000;
    check1("btn_held_restart", gra_still_a, 1'b0);

    // Saturation at 99 on the never-winning instance (l_score 10 -> 99)
    repeat (89) begin miss(1'b0, 1'b1); resume(); end
    check8("l_score_99", l_score_b, 8'h99);
    miss(1'b0, 1'b1);
    check8("bcd_sat", l_score_b, 8'h99);
    check1("sat_serve", gra_still_b, 1'b1);
    resume();

    // Rally saturation, then reset mid-rally
    repeat (260) begin l_hit = 1'b1; tick(); l_hit = 1'b0; tick(); end
    check8("rally_sat", rally_b, 8'hFF);
    #2 reset = 1'b0;
    #1;
    check8("midrst_l_score", l_score_b, 8'h00);
    check8("midrst_r_score", r_score_b, 8'h00);
    check8("midrst_rally", rally_b, 8'h00);
    check1("midrst_still", gra_still_b, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check1("idle_after_midrst", gra_still_b, 1'b1);
    check8("idle_after_midrst_l", l_score_b, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
